// File: rtl/uart_ctrl_if.sv
// uart_ctrl streaming bundle: TX push side and RX pop side.
// master = fabric logic, slave = uart_ctrl.
interface uart_ctrl_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;

    modport master (
        output tx_data, tx_valid, rx_ready,
        input  tx_ready, rx_data, rx_valid
    );

    modport slave (
        input  tx_data, tx_valid, rx_ready,
        output tx_ready, rx_data, rx_valid
    );
endinterface

// File: rtl/uart_ctrl.sv
// Full-duplex UART with FWFT TX/RX FIFOs, parity, 1/2 stop bits.
// Optional internal loopback when UART_LOOPBACK_EN is defined.
module uart_ctrl_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     nrst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) &&
                     (wptr[AW-1:0] == rptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || pop);
    assign level   = wptr - rptr;
    assign dout    = empty ? '0 : mem[rptr[AW-1:0]];

    // Pointer advance; extra MSB distinguishes full from empty.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    // Storage write; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= din;
    end
endmodule

module uart_ctrl #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         nrst,
    input  logic [15:0]                  baud_div,
    uart_ctrl_if.slave                   bus,
    output logic                         port_tx,
    input  logic                         port_rx,
    output logic                         tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]  tx_level,
    output logic [$clog2(FIFO_DEPTH):0]  rx_level,
    output logic                         err_frame,
    output logic                         err_parity,
    output logic                         err_overrun,
    input  logic                         err_clr,
    input  logic                         loopback
);
    localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);
    localparam logic       ODD       = (PARITY == 2);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PAR, S_STOP
    } state_t;

    state_t               tx_state, tx_state_d;
    logic [DATA_BITS-1:0] tx_dout, tx_sh;
    logic                 tx_full, tx_empty, tx_push, tx_pop;
    logic                 tx_par, tx_line, tx_tick, tx_bend;
    logic [15:0]          tx_div, tx_pcnt;
    logic [3:0]           tx_tcnt, tx_bidx;

    state_t               rx_state, rx_state_d;
    logic [DATA_BITS-1:0] rx_sh;
    logic                 rx_full, rx_empty, rx_push, rx_pop;
    logic                 rx_in, rx_s, rx_prev, rx_fall;
    logic [1:0]           rx_sync;
    logic                 rx_s7, rx_s8, rx_maj, rx_parb, rx_par_ok;
    logic                 rx_load, rx_tick, rx_bend, rx_mid;
    logic                 set_frame, set_parity, set_overrun;
    logic [15:0]          rx_div, rx_pcnt;
    logic [3:0]           rx_tcnt, rx_bidx;

`ifdef UART_LOOPBACK_EN
    assign port_tx = loopback ? 1'b1 : tx_line;
    assign rx_in   = loopback ? tx_line : port_rx;
`else
    logic unused_loopback;
    assign unused_loopback = loopback;
    assign port_tx = tx_line;
    assign rx_in   = port_rx;
`endif

    assign tx_push      = bus.tx_valid && !tx_full;
    assign bus.tx_ready = !tx_full;
    assign bus.rx_valid = !rx_empty;
    assign rx_pop       = bus.rx_ready && !rx_empty;
    assign tx_busy      = (tx_state != S_IDLE);

    uart_ctrl_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .nrst(nrst), .push(tx_push), .pop(tx_pop),
        .din(bus.tx_data), .dout(tx_dout), .full(tx_full),
        .empty(tx_empty), .level(tx_level)
    );

    uart_ctrl_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .nrst(nrst), .push(rx_push), .pop(rx_pop),
        .din(rx_sh), .dout(bus.rx_data), .full(rx_full),
        .empty(rx_empty), .level(rx_level)
    );

    // TX state register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) tx_state <= S_IDLE;
        else       tx_state <= tx_state_d;
    end

    // TX next state, FIFO pop and serial line level.
    always_comb begin
        tx_state_d = tx_state;
        tx_pop     = 1'b0;
        tx_line    = 1'b1;
        tx_tick    = (tx_state != S_IDLE) && (tx_pcnt == tx_div);
        tx_bend    = tx_tick && (tx_tcnt == 4'd15);
        unique case (tx_state)
            S_IDLE: begin
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_state_d = S_START;
                end
            end
            S_START: begin
                tx_line = 1'b0;
                if (tx_bend) tx_state_d = S_DATA;
            end
            S_DATA: begin
                tx_line = tx_sh[0];
                if (tx_bend && tx_bidx == LAST_DATA)
                    tx_state_d = (PARITY != 0) ? S_PAR : S_STOP;
            end
            S_PAR: begin
                tx_line = tx_par;
                if (tx_bend) tx_state_d = S_STOP;
            end
            S_STOP: begin
                if (tx_bend && tx_bidx == LAST_STOP) begin
                    tx_pop     = !tx_empty;
                    tx_state_d = tx_empty ? S_IDLE : S_START;
                end
            end
            default: tx_state_d = S_IDLE;
        endcase
    end

    // TX datapath: shifter load at pop, prescaler, tick and bit counters.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            tx_sh   <= '0;
            tx_par  <= 1'b0;
            tx_div  <= '0;
            tx_pcnt <= '0;
            tx_tcnt <= '0;
            tx_bidx <= '0;
        end else if (tx_pop) begin
            tx_sh   <= tx_dout;
            tx_par  <= (^tx_dout) ^ ODD;
            tx_div  <= baud_div;
            tx_pcnt <= '0;
            tx_tcnt <= '0;
            tx_bidx <= '0;
        end else if (tx_state != S_IDLE) begin
            tx_pcnt <= tx_tick ? 16'd0 : tx_pcnt + 16'd1;
            if (tx_tick) tx_tcnt <= tx_tcnt + 4'd1;
            if (tx_bend) begin
                tx_bidx <= (tx_state_d != tx_state) ? 4'd0 : tx_bidx + 4'd1;
                if (tx_state == S_DATA) tx_sh <= tx_sh >> 1;
            end
        end
    end

    // Two-flop synchroniser plus previous value for edge detection.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rx_sync <= 2'b11;
            rx_prev <= 1'b1;
        end else begin
            rx_sync <= {rx_sync[0], rx_in};
            rx_prev <= rx_s;
        end
    end

    assign rx_s      = rx_sync[1];
    assign rx_fall   = rx_prev && !rx_s;
    assign rx_maj    = (rx_s7 & rx_s8) | (rx_s7 & rx_s) | (rx_s8 & rx_s);
    assign rx_par_ok = (PARITY == 0) || (rx_parb == ((^rx_sh) ^ ODD));

    // RX state register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) rx_state <= S_IDLE;
        else       rx_state <= rx_state_d;
    end

    // RX next state and word disposition at the stop-bit sample.
    always_comb begin
        rx_state_d  = rx_state;
        rx_load     = 1'b0;
        rx_push     = 1'b0;
        set_frame   = 1'b0;
        set_parity  = 1'b0;
        set_overrun = 1'b0;
        rx_tick     = (rx_state != S_IDLE) && (rx_pcnt == rx_div);
        rx_bend     = rx_tick && (rx_tcnt == 4'd15);
        rx_mid      = rx_tick && (rx_tcnt == 4'd9);
        unique case (rx_state)
            S_IDLE: begin
                if (rx_fall) begin
                    rx_load    = 1'b1;
                    rx_state_d = S_START;
                end
            end
            S_START: begin
                if (rx_mid && rx_maj) rx_state_d = S_IDLE;
                else if (rx_bend)     rx_state_d = S_DATA;
            end
            S_DATA: begin
                if (rx_bend && rx_bidx == LAST_DATA)
                    rx_state_d = (PARITY != 0) ? S_PAR : S_STOP;
            end
            S_PAR: begin
                if (rx_bend) rx_state_d = S_STOP;
            end
            S_STOP: begin
                if (rx_mid) begin
                    rx_state_d = S_IDLE;
                    if (!rx_maj)                  set_frame   = 1'b1;
                    else if (!rx_par_ok)          set_parity  = 1'b1;
                    else if (rx_full && !rx_pop)  set_overrun = 1'b1;
                    else                          rx_push     = 1'b1;
                end
            end
            default: rx_state_d = S_IDLE;
        endcase
    end

    // RX datapath: prescaler, mid-bit samples, shifter and parity bit.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rx_sh   <= '0;
            rx_parb <= 1'b0;
            rx_s7   <= 1'b1;
            rx_s8   <= 1'b1;
            rx_div  <= '0;
            rx_pcnt <= '0;
            rx_tcnt <= '0;
            rx_bidx <= '0;
        end else if (rx_load) begin
            rx_div  <= baud_div;
            rx_pcnt <= '0;
            rx_tcnt <= '0;
            rx_bidx <= '0;
        end else if (rx_state != S_IDLE) begin
            rx_pcnt <= rx_tick ? 16'd0 : rx_pcnt + 16'd1;
            if (rx_tick) rx_tcnt <= rx_tcnt + 4'd1;
            if (rx_tick && rx_tcnt == 4'd7) rx_s7 <= rx_s;
            if (rx_tick && rx_tcnt == 4'd8) rx_s8 <= rx_s;
            if (rx_mid && rx_state == S_DATA)
                rx_sh <= {rx_maj, rx_sh[DATA_BITS-1:1]};
            if (rx_mid && rx_state == S_PAR) rx_parb <= rx_maj;
            if (rx_bend)
                rx_bidx <= (rx_state_d != rx_state) ? 4'd0 : rx_bidx + 4'd1;
        end
    end

    // Sticky errors; a set in the same cycle as err_clr wins.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            err_frame   <= 1'b0;
            err_parity  <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            err_frame   <= set_frame   | (err_frame   & ~err_clr);
            err_parity  <= set_parity  | (err_parity  & ~err_clr);
            err_overrun <= set_overrun | (err_overrun & ~err_clr);
        end
    end
endmodule

// File: doc/uart_ctrl.md
Name: uart_ctrl

Overview:
Parametrised full-duplex UART controller with internal TX/RX FIFOs, valid/ready streaming interfaces, runtime baud divisor, optional parity, 1 or 2 stop bits and sticky error reporting. Sits between fabric logic and the board's serial pins. It is the general-purpose successor to the fixed-format pulse-driven UART core. FIFOs are implemented inside this block as first-word-fall-through circular buffers.

Parameters:
DATA_BITS, 8, data bits per frame; legal 5..9
PARITY, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, stop bits transmitted; legal 1 or 2
FIFO_DEPTH, 16, entries per FIFO; power of 2, >= 2

Ports:
clk  in  1  system clock
nrst  in  1  asynchronous active-low reset
baud_div  in  16  oversample tick period minus 1; bit time = 16*(baud_div+1) clk
tx_data  in  DATA_BITS  word to transmit
tx_valid  in  1  tx_data valid
tx_ready  out  1  TX FIFO not full
rx_data  out  DATA_BITS  RX FIFO head
rx_valid  out  1  RX FIFO not empty
rx_ready  in  1  pop RX head
port_tx  out  1  serial out, idle high
port_rx  in  1  serial in, asynchronous
tx_busy  out  1  TX frame in progress
tx_level  out  $clog2(FIFO_DEPTH)+1  TX FIFO occupancy
rx_level  out  $clog2(FIFO_DEPTH)+1  RX FIFO occupancy
err_frame  out  1  sticky: stop bit sampled low
err_parity  out  1  sticky: parity mismatch
err_overrun  out  1  sticky: good word dropped, RX FIFO full
err_clr  in  1  clear all sticky errors
loopback  in  1  internal loopback select (macro only)

Behaviour:
- Reset (async, nrst low): port_tx=1, tx_busy=0, tx_ready=1, rx_valid=0, rx_data=0, levels 0, errors 0, both FSMs IDLE, prescalers 0. Mid-frame reset aborts frames immediately; FIFO contents lost.
- FIFOs: push on valid&&ready; pointers carry an extra wrap bit; full/empty from pointer compare. rx_data is the head, combinational from storage.
- TX FIFO: push on tx_valid&&tx_ready; push ignored when full.
- RX FIFO: push while full is accepted when rx_ready pops in the same cycle; no overrun in that case.
- Prescaler: per-engine, reloaded at frame start. A baud_div change mid-frame takes effect at next reload; frame may corrupt; no error raised.
- TX FSM IDLE->START->DATA->PARITY (skipped if PARITY=0)->STOP->IDLE.
- IDLE with FIFO non-empty: pop, load shifter, port_tx=0, tx_busy=1, same edge. First entry pushed into an empty FIFO at edge N is popped at edge N+1.
- Each TX bit lasts 16 ticks. Data LSB first. Even parity = XOR(data); odd = ~XOR(data). STOP holds 1 for STOP_BITS bit times.
- TX back-to-back frames: at most 1 clk idle between frames. tx_busy falls at end of the last stop bit if FIFO empty.
- RX: 2-flop synchroniser on port_rx (2 clk latency).
- RX IDLE waits for synced 1->0.
- RX START: majority of samples at ticks 7,8,9. Majority 1 = false start -> IDLE, no error.
- RX DATA/PARITY: each bit is the majority of ticks 7,8,9 of its bit time.
- RX STOP: checks only the first stop bit at mid-bit, then returns to IDLE.
- RX word disposition, in priority order:
  1. Stop sample 0: word discarded, err_frame=1.
  2. Parity mismatch: word discarded, err_parity=1.
  3. RX FIFO full and no simultaneous pop: word dropped, err_overrun=1.
  4. Otherwise the word is pushed.
- After a frame error, IDLE requires the line to return high before the next falling edge is accepted.
- Error flags: err_clr clears all three. A set event in the same cycle as err_clr wins (flag stays 1).

Optional Feature:
UART_LOOPBACK_EN: when defined and loopback=1, the RX synchroniser input is taken from internal TX serial and port_tx is held 1. When not defined, the loopback input is ignored and the path is not synthesised.

Test Plan:
- PARITY=0, baud_div=0, port_tx tied to port_rx, push 0xA5 -> port_tx low 16 clk; bits 1,0,1,0,0,1,0,1 at 16 clk each; 16 clk high; rx_valid=1, rx_data=0xA5, no errors.
- PARITY=1, push 0x07 -> parity bit 1 on line. Inject 0x07 with parity 0 -> err_parity=1, rx_level stays 0.
- Inject 0x55 with stop bit 0 -> err_frame=1, rx_valid=0. Pulse err_clr -> err_frame=0. Next valid frame 0x3C received correctly.
- FIFO_DEPTH=4, inject 5 frames 0x01..0x05, no pops -> rx_level=4, err_overrun=1; pops return 0x01..0x04.
- FIFO_DEPTH=16, tx_valid high 18 consecutive cycles from reset -> 17 accepted, tx_level=16, tx_ready=0; port_tx frames in push order.
- nrst low during TX DATA phase -> port_tx=1 and tx_busy=0 asynchronously. After release, tx_level=0 and no further frames.
